// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Consumers: regfile_mp (top) and regfile_scoreboard.
package regfile_pkg;

   // Bulk-clear sequencer states
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // Number of registers addressed by an address of the given width
   function automatic int regfile_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: reservations set a bit, writes clear it,
// a bulk-clear start wipes the whole vector. Register 0 is never pending.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   input  logic                     bulk_clr_i,
   input  logic                     hold_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]        rd_pend_o
);

   localparam int DEPTH = regfile_depth(ADDR_W);

   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;

   // Next pend vector: bulk clear dominates; otherwise writes clear, then a
   // reservation sets (so reserve wins over a same-cycle write)
   always_comb begin
      pend_d = pend_q;
      if (bulk_clr_i) begin
         pend_d = '0;
      end else if (!hold_i) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i]) begin
               pend_d[wr_addr_i[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
         end
         if (rsv_en_i) begin
            pend_d[rsv_addr_i] = 1'b1;
         end
      end
      pend_d[0] = 1'b0;
   end

   // Pend vector register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Per-port pend lookup
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
         assign rd_pend_o[gi] = pend_q[rd_addr_i[gi*ADDR_W +: ADDR_W]];
      end
   endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending scoreboard and a
// multi-cycle bulk-clear sequencer.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data to
// matching read ports and masks their pending flag.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_pend_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   input  logic                     clr_req_i,
   output logic                     clr_busy_o
);

   localparam int DEPTH = regfile_depth(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              in_clear;
   logic              clr_start;
   logic [NUM_RD-1:0] sb_pend;

   assign in_clear   = (state_q == CLEAR);
   assign clr_start  = (state_q == IDLE) && clr_req_i;
   assign clr_busy_o = in_clear;

   // Clear sequencer: walks the counter from 1 to DEPTH-1 (register 0 is
   // already hard zero), then returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req_i) begin
                  state_q <= CLEAR;
                  cnt_q   <= ADDR_W'(1);
               end
            end
            CLEAR: begin
               if (cnt_q == LAST_IDX) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Storage: sequencer zeroes one entry per cycle while clearing; otherwise
   // port writes in ascending order so the highest index wins on collisions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_q[r] <= '0;
         end
      end else if (in_clear) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i] && (wr_addr_i[i*ADDR_W +: ADDR_W] != '0)) begin
               mem_q[wr_addr_i[i*ADDR_W +: ADDR_W]] <= wr_data_i[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .rsv_en_i   (rsv_en_i),
      .rsv_addr_i (rsv_addr_i),
      .bulk_clr_i (clr_start),
      .hold_i     (in_clear),
      .rd_addr_i  (rd_addr_i),
      .rd_pend_o  (sb_pend)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] rdata;
         logic              hit;

         assign ra = rd_addr_i[gi*ADDR_W +: ADDR_W];

         // Read mux, optionally overridden by a matching in-flight write
         always_comb begin
            rdata = mem_q[ra];
            hit   = 1'b0;
`ifdef REGFILE_BYPASS_EN
            if (!in_clear && (ra != '0)) begin
               for (int i = 0; i < NUM_WR; i++) begin
                  if (wr_en_i[i] && (wr_addr_i[i*ADDR_W +: ADDR_W] == ra)) begin
                     rdata = wr_data_i[i*DATA_W +: DATA_W];
                     hit   = 1'b1;
                  end
               end
            end
`endif
         end

         assign rd_data_o[gi*DATA_W +: DATA_W] = rdata;
         assign rd_pend_o[gi] = sb_pend[gi] & ~hit;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters). Expected values
// are hand-derived; bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_pend;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        clr_req;
   logic        clr_busy;

   int n_total = 0;
   int n_pass  = 0;
   int busy_cnt;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W (32),
      .ADDR_W (5),
      .NUM_RD (2),
      .NUM_WR (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_pend_o  (rd_pend),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .clr_req_i  (clr_req),
      .clr_busy_o (clr_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic rd_chk(input string tag, input int port, input logic [4:0] a,
                         input logic [31:0] ed, input logic ep);
      rd_addr[port*5 +: 5] = a;
      #1;
      chk({tag, "_data"}, rd_data[port*32 +: 32], ed);
      chk({tag, "_pend"}, {31'b0, rd_pend[port]}, {31'b0, ep});
   endtask

   task automatic wr_set(input int port, input logic [4:0] a, input logic [31:0] d);
      wr_en[port]          = 1'b1;
      wr_addr[port*5 +: 5] = a;
      wr_data[port*32 +: 32] = d;
   endtask

   // Count cycles with clr_busy high (bounded); optionally hammer writes,
   // reservations and clr_req during the sequence, which must all be ignored
   task automatic count_busy(input bit junk, output int n);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (!clr_busy) break;
         n++;
         if (junk) begin
            wr_set(0, 5'd31, 32'h0000_0BAD);
            wr_set(1, 5'd4,  32'h0000_0BAD);
            rsv_en   = 1'b1;
            rsv_addr = 5'd13;
            clr_req  = 1'b1;
            if (c == 0) rd_chk("clr_nobyp31", 0, 5'd31, 32'hF000_001F, 1'b0);
         end
         step();
         wr_en   = '0;
         rsv_en  = 1'b0;
         clr_req = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
      repeat (3) step();
      chk("rst_busy", {31'b0, clr_busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // Reset state on both read ports
      for (int a = 0; a < 32; a++) begin
         rd_chk("rst_p0", 0, 5'(a), 32'd0, 1'b0);
         rd_chk("rst_p1", 1, 5'(31 - a), 32'd0, 1'b0);
      end
      chk("idle_busy", {31'b0, clr_busy}, 32'd0);

      // Write priority: port 1 wins on the same address
      wr_set(0, 5'd5, 32'hDEAD_BEEF);
      wr_set(1, 5'd5, 32'h1234_5678);
      step();
      wr_en = '0;
      rd_chk("wr_prio_r5", 0, 5'd5, 32'h1234_5678, 1'b0);

      // r0 is never written; other port still writes
      wr_set(0, 5'd0, 32'hFFFF_FFFF);
      wr_set(1, 5'd3, 32'h0000_0033);
      step();
      wr_en = '0;
      rd_chk("r0_zero", 0, 5'd0, 32'd0, 1'b0);
      rd_chk("r3_wr", 1, 5'd3, 32'h0000_0033, 1'b0);

      // Same-cycle write/read of r7
      wr_set(0, 5'd7, 32'h1111_1111);
      step();
      wr_en = '0;
      rd_chk("pre_r7", 0, 5'd7, 32'h1111_1111, 1'b0);
      wr_set(0, 5'd7, 32'hA5A5_A5A5);
      rd_chk("byp_r7", 0, 5'd7, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, 1'b0);
      step();
      wr_en = '0;
      rd_chk("post_r7", 0, 5'd7, 32'hA5A5_A5A5, 1'b0);

      // No forwarding onto r0
      wr_set(1, 5'd0, 32'hFFFF_FFFF);
      rd_chk("byp_r0", 1, 5'd0, 32'd0, 1'b0);
      step();
      wr_en = '0;

      // Reservation of r9
      rsv_en = 1'b1; rsv_addr = 5'd9;
      rd_chk("rsv9_pre", 0, 5'd9, 32'd0, 1'b0);
      step();
      rsv_en = 1'b0;
      rd_chk("rsv9_p0", 0, 5'd9, 32'd0, 1'b1);
      rd_chk("rsv9_p1", 1, 5'd9, 32'd0, 1'b1);

      // Write retires the reservation
      wr_set(1, 5'd9, 32'h0000_0099);
      rd_chk("wr9_same", 0, 5'd9, BYP ? 32'h0000_0099 : 32'd0, BYP ? 1'b0 : 1'b1);
      step();
      wr_en = '0;
      rd_chk("wr9_after", 0, 5'd9, 32'h0000_0099, 1'b0);

      // Reserve and write together: data lands, pend stays set
      rsv_en = 1'b1; rsv_addr = 5'd9;
      wr_set(0, 5'd9, 32'h0000_009A);
      step();
      wr_en = '0; rsv_en = 1'b0;
      rd_chk("rsvwr9", 0, 5'd9, 32'h0000_009A, 1'b1);

      // r0 can never become pending
      rsv_en = 1'b1; rsv_addr = 5'd0;
      step();
      rsv_en = 1'b0;
      rd_chk("rsv_r0", 0, 5'd0, 32'd0, 1'b0);

      // Fill r1..r31 and reserve r12
      for (int a = 1; a < 32; a++) begin
         wr_set(0, 5'(a), 32'hF000_0000 | 32'(a));
         step();
      end
      wr_en = '0;
      rsv_en = 1'b1; rsv_addr = 5'd12;
      step();
      rsv_en = 1'b0;
      rd_chk("fill_r31", 0, 5'd31, 32'hF000_001F, 1'b0);
      rd_chk("fill_r12", 1, 5'd12, 32'hF000_000C, 1'b1);

      // Bulk clear with writes/reservations/clr_req ignored while busy
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      chk("clr_busy_on", {31'b0, clr_busy}, 32'd1);
      count_busy(1'b1, busy_cnt);
      chk("clr_len", 32'(busy_cnt), 32'd31);
      step();
      chk("clr_no_restart", {31'b0, clr_busy}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         rd_chk("clr_all", 0, 5'(a), 32'd0, 1'b0);
      end

      // Reset in the middle of a clear sequence
      wr_set(0, 5'd20, 32'h0000_2020);
      wr_set(1, 5'd31, 32'hCAFE_0031);
      step();
      wr_en = '0;
      rsv_en = 1'b1; rsv_addr = 5'd20;
      step();
      rsv_en = 1'b0;
      rd_chk("mid_pre_r20", 0, 5'd20, 32'h0000_2020, 1'b1);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (9) step();
      chk("mid_busy", {31'b0, clr_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, clr_busy}, 32'd0);
      rd_chk("mid_rst_r31", 0, 5'd31, 32'd0, 1'b0);
      rd_chk("mid_rst_r20", 1, 5'd20, 32'd0, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      count_busy(1'b0, busy_cnt);
      chk("restart_len", 32'(busy_cnt), 32'd31);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
